rf_wb_arbiter: RTL

Round-robin arbiter that shares the single register-file write port among several writeback requesters, such as the ALU result, load data and the multiply/divide unit. It drives the register file's `we`/`waddr`/`wdata` from one registered output stage. It accepts at most one write per cycle, guarantees bounded wait for every requester, and drops writes to `$zero` at the arbiter.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 43 ++++
 rtl/rf_wb_arbiter.sv | 99 +++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Register-file shared constants and address/data types.
package rf_pkg;

  localparam int unsigned RF_AW   = 5;
  localparam int unsigned RF_DW   = 32;
  localparam int unsigned RF_NREG = 32;
  localparam logic [RF_AW-1:0] RF_ZERO = 5'd0;

  typedef logic [RF_AW-1:0] rf_addr_t;
  typedef logic [RF_DW-1:0] rf_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from ptr with wrap;
// ptr moves past the winner whenever the grant is taken.
module rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] ptr_q, ptr_d;
  logic          found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!found && req[PW'((32'(ptr_q) + i) % N)]) begin
        gnt[PW'((32'(ptr_q) + i) % N)] = 1'b1;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (gnt[PW'(j)]) ptr_d = PW'((j + 1) % N);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin over NREQ requesters into one
// registered write port; writes to $zero are accepted but never performed.
// Optional combinational bypass of the landing write under RF_WB_ARB_FWD_EN.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = RF_AW,
  parameter int unsigned DW   = RF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
`ifdef RF_WB_ARB_FWD_EN
  input  logic [AW-1:0]     fwd_raddr1,
  input  logic [AW-1:0]     fwd_raddr2,
  output logic              fwd_hit1,
  output logic              fwd_hit2,
  output logic [DW-1:0]     fwd_data1,
  output logic [DW-1:0]     fwd_data2,
`endif
  output logic              rf_we,
  output logic [AW-1:0]     rf_waddr,
  output logic [DW-1:0]     rf_wdata
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0] gnt;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;

  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

  rr_arbiter #(.N(NREQ)) u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req_valid),
    .advance (xfer),
    .gnt     (gnt)
  );

  // The grant is only ever raised on a valid requester, so ready == grant.
  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[PW'(i)]) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  always_comb begin
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (xfer) begin
      rf_we_d    = (sel_addr != AW'(RF_ZERO));
      rf_waddr_d = sel_addr;
      rf_wdata_d = sel_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

`ifdef RF_WB_ARB_FWD_EN
  // Bypass lets decode see the write landing this cycle.
  assign fwd_hit1  = rf_we_q && (fwd_raddr1 == rf_waddr_q) && (fwd_raddr1 != AW'(RF_ZERO));
  assign fwd_hit2  = rf_we_q && (fwd_raddr2 == rf_waddr_q) && (fwd_raddr2 != AW'(RF_ZERO));
  assign fwd_data1 = fwd_hit1 ? rf_wdata_q : '0;
  assign fwd_data2 = fwd_hit2 ? rf_wdata_q : '0;
`endif

endmodule
